// File: rtl/mem_request_arbiter.sv
// Single-outstanding memory arbiter for fetch, load and store requesters.
// Fixed priority store > load > fetch, with a starvation guard for fetch; flush handling stays local.
module mem_request_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_signal,
    input  logic        ic_req_en,
    input  logic [31:0] ic_req_addr,
    output logic        ic_resp_en,
    output logic [31:0] ic_resp_data,
    input  logic        ld_req_en,
    input  logic [31:0] ld_req_addr,
    input  logic [1:0]  ld_req_width,
    output logic        ld_resp_en,
    output logic [31:0] ld_resp_data,
    input  logic        st_req_en,
    input  logic [31:0] st_req_addr,
    input  logic [1:0]  st_req_width,
    input  logic [31:0] st_req_data,
    output logic        st_resp_en,
    output logic        mem_req_en,
    output logic        mem_req_type,
    output logic [31:0] mem_req_addr,
    output logic [1:0]  mem_req_width,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_en,
    input  logic [31:0] mem_resp_data
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COOL} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

    state_t        state, next_state;
    owner_t        owner, next_owner;
    logic [CW-1:0] starve_cnt, next_starve_cnt;
    logic          deliver, next_deliver;
    logic          grant, complete, fetch_forced;
    logic          req_type;
    logic [31:0]   req_addr, req_data;
    logic [1:0]    req_width;
    logic [31:0]   ic_data, ld_data;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            deliver    <= 1'b0;
        end else if (rdy_in) begin
            state      <= next_state;
            owner      <= next_owner;
            starve_cnt <= next_starve_cnt;
            deliver    <= next_deliver;
        end
    end

    // Request fields are captured at grant time; read data only when the response is delivered.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            req_type  <= 1'b0;
            req_addr  <= '0;
            req_width <= '0;
            req_data  <= '0;
            ic_data   <= '0;
            ld_data   <= '0;
        end else if (rdy_in) begin
            if (grant) begin
                case (next_owner)
                    OWN_STORE: begin
                        req_type  <= 1'b1;
                        req_addr  <= st_req_addr;
                        req_width <= st_req_width;
                        req_data  <= st_req_data;
                    end
                    OWN_LOAD: begin
                        req_type  <= 1'b0;
                        req_addr  <= ld_req_addr;
                        req_width <= ld_req_width;
                        req_data  <= '0;
                    end
                    default: begin
                        req_type  <= 1'b0;
                        req_addr  <= ic_req_addr;
                        req_width <= 2'd2;
                        req_data  <= '0;
                    end
                endcase
            end
            if (complete && next_deliver && owner == OWN_LOAD)
                ld_data <= mem_resp_data;
            if (complete && next_deliver && owner == OWN_FETCH)
                ic_data <= mem_resp_data;
        end
    end

    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_starve_cnt = starve_cnt;
        next_deliver    = deliver;
        grant           = 1'b0;
        complete        = 1'b0;
        fetch_forced    = ic_req_en && (starve_cnt == CW'(STARVE_LIMIT));
        case (state)
            IDLE: begin
                if (!flush_signal && (st_req_en || ld_req_en || ic_req_en)) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                    if (fetch_forced)   next_owner = OWN_FETCH;
                    else if (st_req_en) next_owner = OWN_STORE;
                    else if (ld_req_en) next_owner = OWN_LOAD;
                    else                next_owner = OWN_FETCH;
                end
            end
            ISSUE: begin
                // A flush kills load/fetch responses, even one arriving this very cycle; stores always complete.
                if (mem_resp_en) begin
                    complete     = 1'b1;
                    next_state   = COOL;
                    next_deliver = (owner == OWN_STORE) || !flush_signal;
                end else if (flush_signal && owner != OWN_STORE) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_en) begin
                    complete     = 1'b1;
                    next_state   = COOL;
                    next_deliver = 1'b0;
                end
            end
            COOL: begin
                next_state   = IDLE;
                next_owner   = OWN_NONE;
                next_deliver = 1'b0;
            end
            default: next_state = IDLE;
        endcase
        if (!ic_req_en || (grant && next_owner == OWN_FETCH))
            next_starve_cnt = '0;
        else if (grant && starve_cnt != CW'(STARVE_LIMIT))
            next_starve_cnt = starve_cnt + 1'b1;
    end

    // Response pulses live exactly in the COOL cycle after a delivered completion.
    always_comb begin
        mem_req_en    = (state == ISSUE) || (state == DRAIN);
        mem_req_type  = req_type;
        mem_req_addr  = req_addr;
        mem_req_width = req_width;
        mem_req_data  = req_data;
        ic_resp_en    = (state == COOL) && deliver && (owner == OWN_FETCH);
        ld_resp_en    = (state == COOL) && deliver && (owner == OWN_LOAD);
        st_resp_en    = (state == COOL) && deliver && (owner == OWN_STORE);
        ic_resp_data  = ic_data;
        ld_resp_data  = ld_data;
    end
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed and randomized checks of mem_request_arbiter against a transaction-level model.
module tb_mem_request_arbiter;
    localparam int LIMIT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_signal;
    logic        ic_req_en, ld_req_en, st_req_en;
    logic [31:0] ic_req_addr, ld_req_addr, st_req_addr, st_req_data;
    logic [1:0]  ld_req_width, st_req_width;
    logic        ic_resp_en, ld_resp_en, st_resp_en;
    logic [31:0] ic_resp_data, ld_resp_data;
    logic        mem_req_en, mem_req_type;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [1:0]  mem_req_width;
    logic        mem_resp_en;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    // Model state: one outstanding transaction, a cool-down count, and fetch starvation count.
    bit          m_busy, m_flushed;
    int          m_owner, m_cool, m_cnt;
    logic        m_type;
    logic [31:0] m_addr, m_data, m_ic_data, m_ld_data;
    logic [1:0]  m_width;
    logic [2:0]  m_pulse, new_pulse;
    bit          new_grant;
    int          mem_delay;

    logic        p_rdy, p_flush, p_st, p_ld, p_ic, p_resp;
    logic [31:0] p_rdata, p_st_addr, p_st_data, p_ld_addr, p_ic_addr;
    logic [1:0]  p_st_width, p_ld_width;

    mem_request_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
        .ic_req_en(ic_req_en), .ic_req_addr(ic_req_addr),
        .ic_resp_en(ic_resp_en), .ic_resp_data(ic_resp_data),
        .ld_req_en(ld_req_en), .ld_req_addr(ld_req_addr), .ld_req_width(ld_req_width),
        .ld_resp_en(ld_resp_en), .ld_resp_data(ld_resp_data),
        .st_req_en(st_req_en), .st_req_addr(st_req_addr), .st_req_width(st_req_width),
        .st_req_data(st_req_data), .st_resp_en(st_resp_en),
        .mem_req_en(mem_req_en), .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
        .mem_req_width(mem_req_width), .mem_req_data(mem_req_data),
        .mem_resp_en(mem_resp_en), .mem_resp_data(mem_resp_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk_in);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_req_en"}, 32'(mem_req_en), 32'd0);
        checkOutput({tag, " mem_req_type"}, 32'(mem_req_type), 32'd0);
        checkOutput({tag, " mem_req_addr"}, mem_req_addr, 32'd0);
        checkOutput({tag, " mem_req_width"}, 32'(mem_req_width), 32'd0);
        checkOutput({tag, " mem_req_data"}, mem_req_data, 32'd0);
        checkOutput({tag, " resp_en"}, 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'd0);
        checkOutput({tag, " ic_resp_data"}, ic_resp_data, 32'd0);
        checkOutput({tag, " ld_resp_data"}, ld_resp_data, 32'd0);
    endtask

    task automatic waitGrant(input string tag, input int budget);
        int n = 0;
        while (!mem_req_en && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, 32'(mem_req_en), 32'd1);
    endtask

    task automatic serveMem(input int delay, input logic [31:0] data);
        applyStimulus(delay);
        mem_resp_en   = 1'b1;
        mem_resp_data = data;
        applyStimulus(1);
        mem_resp_en   = 1'b0;
    endtask

    task automatic latchInputs();
        p_rdy = rdy_in; p_flush = flush_signal; p_resp = mem_resp_en; p_rdata = mem_resp_data;
        p_st = st_req_en; p_st_addr = st_req_addr; p_st_width = st_req_width; p_st_data = st_req_data;
        p_ld = ld_req_en; p_ld_addr = ld_req_addr; p_ld_width = ld_req_width;
        p_ic = ic_req_en; p_ic_addr = ic_req_addr;
    endtask

    // One enabled clock edge of the arbiter's rules, applied to the inputs held across that edge.
    task automatic modelStep();
        int win = -1;
        new_pulse = 3'b000;
        new_grant = 1'b0;
        if (!p_rdy) return;
        m_pulse = 3'b000;
        if (m_cool > 0) begin
            m_cool--;
        end else if (m_busy) begin
            if (p_resp) begin
                m_busy = 1'b0;
                m_cool = 1;
                if (m_owner == 2) m_pulse = 3'b100;
                else if (!(m_flushed || p_flush)) begin
                    if (m_owner == 1) begin m_pulse = 3'b010; m_ld_data = p_rdata; end
                    else              begin m_pulse = 3'b001; m_ic_data = p_rdata; end
                end
                new_pulse = m_pulse;
            end else if (p_flush && m_owner != 2) begin
                m_flushed = 1'b1;
            end
        end else if (!p_flush) begin
            if (p_ic && m_cnt == LIMIT) win = 0;
            else if (p_st)              win = 2;
            else if (p_ld)              win = 1;
            else if (p_ic)              win = 0;
            if (win >= 0) begin
                m_busy = 1'b1; m_flushed = 1'b0; m_owner = win; new_grant = 1'b1;
                case (win)
                    2:       begin m_type = 1'b1; m_addr = p_st_addr; m_width = p_st_width; m_data = p_st_data; end
                    1:       begin m_type = 1'b0; m_addr = p_ld_addr; m_width = p_ld_width; end
                    default: begin m_type = 1'b0; m_addr = p_ic_addr; m_width = 2'd2; end
                endcase
            end
        end
        if (!p_ic || win == 0)           m_cnt = 0;
        else if (win > 0 && m_cnt < LIMIT) m_cnt++;
    endtask

    initial begin
        logic [31:0] starve_order [4];
        starve_order = '{32'h2000, 32'h2000, 32'h1008, 32'h2000};
        rst_in = 1'b1; rdy_in = 1'b1; flush_signal = 1'b0; mem_resp_en = 1'b0; mem_resp_data = '0;
        ic_req_en = 1'b0; ic_req_addr = '0; ld_req_en = 1'b0; ld_req_addr = '0; ld_req_width = '0;
        st_req_en = 1'b0; st_req_addr = '0; st_req_width = '0; st_req_data = '0;
        applyStimulus(2);
        checkAllZero("reset");
        rst_in = 1'b0;

        // Lone fetch, memory answers three cycles after the request appears.
        ic_req_en = 1'b1; ic_req_addr = 32'h1000;
        applyStimulus(1);
        checkOutput("fetch req_en", 32'(mem_req_en), 32'd1);
        checkOutput("fetch addr", mem_req_addr, 32'h1000);
        checkOutput("fetch width", 32'(mem_req_width), 32'd2);
        checkOutput("fetch type", 32'(mem_req_type), 32'd0);
        serveMem(3, 32'hDEADBEEF);
        checkOutput("fetch resp_en", 32'(ic_resp_en), 32'd1);
        checkOutput("fetch resp_data", ic_resp_data, 32'hDEADBEEF);
        checkOutput("fetch req_en low at resp", 32'(mem_req_en), 32'd0);
        ic_req_en = 1'b0;
        applyStimulus(1);
        checkOutput("fetch pulse width", 32'(ic_resp_en), 32'd0);
        checkOutput("fetch data held", ic_resp_data, 32'hDEADBEEF);
        applyStimulus(1);

        // All three at once: store, load, fetch with one cool cycle between.
        st_req_en = 1'b1; st_req_addr = 32'h30000; st_req_width = 2'd2; st_req_data = 32'h12345678;
        ld_req_en = 1'b1; ld_req_addr = 32'h2000; ld_req_width = 2'd1;
        ic_req_en = 1'b1; ic_req_addr = 32'h1004;
        applyStimulus(1);
        checkOutput("order1 type", 32'(mem_req_type), 32'd1);
        checkOutput("order1 addr", mem_req_addr, 32'h30000);
        checkOutput("order1 data", mem_req_data, 32'h12345678);
        serveMem(1, 32'h0);
        checkOutput("order1 st_resp", 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'b100);
        st_req_en = 1'b0;
        applyStimulus(1);
        checkOutput("order1 cool", 32'(mem_req_en), 32'd0);
        applyStimulus(1);
        checkOutput("order2 req_en", 32'(mem_req_en), 32'd1);
        checkOutput("order2 addr", mem_req_addr, 32'h2000);
        checkOutput("order2 width", 32'(mem_req_width), 32'd1);
        serveMem(2, 32'hA5A50001);
        checkOutput("order2 ld_resp", 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'b010);
        checkOutput("order2 ld_data", ld_resp_data, 32'hA5A50001);
        ld_req_en = 1'b0;
        applyStimulus(1);
        checkOutput("order2 cool", 32'(mem_req_en), 32'd0);
        applyStimulus(1);
        checkOutput("order3 addr", mem_req_en ? mem_req_addr : 32'hFFFFFFFF, 32'h1004);
        serveMem(1, 32'h0BADF00D);
        checkOutput("order3 ic_resp", 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'b001);
        checkOutput("order3 ic_data", ic_resp_data, 32'h0BADF00D);
        ic_req_en = 1'b0;
        applyStimulus(1);

        // Continuous loads with a pending fetch: starvation guard lets fetch in after two loads.
        ld_req_en = 1'b1; ld_req_addr = 32'h2000; ld_req_width = 2'd2;
        ic_req_en = 1'b1; ic_req_addr = 32'h1008;
        for (int k = 0; k < 4; k++) begin
            waitGrant($sformatf("starve grant %0d", k), 10);
            checkOutput($sformatf("starve order %0d", k), mem_req_addr, starve_order[k]);
            serveMem(1, 32'h100 + k);
            if (k == 2) ic_req_en = 1'b0;
        end
        ld_req_en = 1'b0;
        applyStimulus(1);

        // Flush right after a load issues: request drains with no load response.
        ld_req_en = 1'b1; ld_req_addr = 32'h2100; ld_req_width = 2'd0;
        applyStimulus(1);
        checkOutput("flush load issued", 32'(mem_req_en), 32'd1);
        flush_signal = 1'b1; ld_req_en = 1'b0;
        applyStimulus(1);
        flush_signal = 1'b0;
        checkOutput("flush drain req_en", 32'(mem_req_en), 32'd1);
        checkOutput("flush drain no ld_resp a", 32'(ld_resp_en), 32'd0);
        applyStimulus(1);
        checkOutput("flush drain hold", 32'(mem_req_en), 32'd1);
        mem_resp_en = 1'b1; mem_resp_data = 32'h55;
        applyStimulus(1);
        mem_resp_en = 1'b0;
        checkOutput("flush drain no ld_resp b", 32'(ld_resp_en), 32'd0);
        checkOutput("flush drain done", 32'(mem_req_en), 32'd0);
        checkOutput("flush ld_data kept", ld_resp_data, 32'h103);
        ld_req_en = 1'b1; ld_req_addr = 32'h2200;
        applyStimulus(1);
        checkOutput("flush no early grant", 32'(mem_req_en), 32'd0);
        checkOutput("flush drain no ld_resp c", 32'(ld_resp_en), 32'd0);
        applyStimulus(1);
        checkOutput("flush next grant addr", mem_req_en ? mem_req_addr : 32'hFFFFFFFF, 32'h2200);
        serveMem(1, 32'hCAFE0000);
        checkOutput("flush next ld_data", ld_resp_en ? ld_resp_data : 32'hFFFFFFFF, 32'hCAFE0000);
        ld_req_en = 1'b0;
        applyStimulus(1);

        // Flush during an in-flight store does not disturb it; a load raised then waits.
        st_req_en = 1'b1; st_req_addr = 32'h30000; st_req_width = 2'd2; st_req_data = 32'h12345678;
        applyStimulus(1);
        checkOutput("st flush issued", 32'(mem_req_en), 32'd1);
        flush_signal = 1'b1; ld_req_en = 1'b1; ld_req_addr = 32'h2300; ld_req_width = 2'd2;
        applyStimulus(1);
        flush_signal = 1'b0;
        checkOutput("st flush held", 32'(mem_req_en), 32'd1);
        checkOutput("st flush addr", mem_req_addr, 32'h30000);
        serveMem(1, 32'h0);
        checkOutput("st flush st_resp", 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'b100);
        checkOutput("st flush req low", 32'(mem_req_en), 32'd0);
        st_req_en = 1'b0;
        applyStimulus(2);
        checkOutput("st flush then load", mem_req_en ? mem_req_addr : 32'hFFFFFFFF, 32'h2300);
        serveMem(1, 32'h77);
        checkOutput("st flush load resp", 32'(ld_resp_en), 32'd1);
        ld_req_en = 1'b0;
        applyStimulus(1);

        // Flush in IDLE holds off a store for that cycle.
        st_req_en = 1'b1; st_req_addr = 32'h30004; st_req_data = 32'h9;
        flush_signal = 1'b1;
        applyStimulus(1);
        flush_signal = 1'b0;
        checkOutput("idle flush no grant", 32'(mem_req_en), 32'd0);
        applyStimulus(1);
        checkOutput("idle flush later grant", mem_req_en ? mem_req_addr : 32'hFFFFFFFF, 32'h30004);
        serveMem(1, 32'h0);
        checkOutput("idle flush st_resp", 32'(st_resp_en), 32'd1);
        st_req_en = 1'b0;
        applyStimulus(1);

        // Stall: response ignored while not ready, pulse held across stalled cycles.
        ic_req_en = 1'b1; ic_req_addr = 32'h1010;
        applyStimulus(1);
        checkOutput("stall issued", 32'(mem_req_en), 32'd1);
        rdy_in = 1'b0; mem_resp_en = 1'b1; mem_resp_data = 32'h1111;
        applyStimulus(2);
        checkOutput("stall ignores resp", 32'({mem_req_en, ic_resp_en}), 32'b10);
        rdy_in = 1'b1; mem_resp_data = 32'h2222;
        applyStimulus(1);
        mem_resp_en = 1'b0;
        checkOutput("stall resp data", ic_resp_en ? ic_resp_data : 32'hFFFFFFFF, 32'h2222);
        ic_req_en = 1'b0; rdy_in = 1'b0;
        applyStimulus(2);
        checkOutput("stall pulse held", 32'(ic_resp_en), 32'd1);
        rdy_in = 1'b1;
        applyStimulus(1);
        checkOutput("stall pulse ends", 32'(ic_resp_en), 32'd0);

        // Reset mid-transaction clears everything before the next edge.
        ld_req_en = 1'b1; ld_req_addr = 32'h2400;
        applyStimulus(1);
        checkOutput("reset issued", 32'(mem_req_en), 32'd1);
        #2 rst_in = 1'b1;
        #1 checkAllZero("async reset");
        ld_req_en = 1'b0;
        applyStimulus(1);
        rst_in = 1'b0;

        // Random traffic against the model.
        m_busy = 0; m_flushed = 0; m_owner = 0; m_cool = 0; m_cnt = 0; m_pulse = '0;
        m_type = 0; m_addr = '0; m_data = '0; m_width = '0; m_ic_data = '0; m_ld_data = '0;
        mem_delay = 0;
        latchInputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(1);
            modelStep();
            checkOutput("rnd mem_req_en", 32'(mem_req_en), 32'(m_busy));
            if (m_busy) begin
                checkOutput("rnd mem_req_addr", mem_req_addr, m_addr);
                checkOutput("rnd mem_req_type", 32'(mem_req_type), 32'(m_type));
                checkOutput("rnd mem_req_width", 32'(mem_req_width), 32'(m_width));
                if (m_type) checkOutput("rnd mem_req_data", mem_req_data, m_data);
            end
            checkOutput("rnd resp pulses", 32'({st_resp_en, ld_resp_en, ic_resp_en}), 32'(m_pulse));
            checkOutput("rnd ic_resp_data", ic_resp_data, m_ic_data);
            checkOutput("rnd ld_resp_data", ld_resp_data, m_ld_data);

            if (new_pulse[2]) st_req_en = 1'b0;
            if (new_pulse[1]) ld_req_en = 1'b0;
            if (new_pulse[0]) ic_req_en = 1'b0;
            if (mem_resp_en && !m_busy) mem_resp_en = 1'b0;
            if (new_grant) mem_delay = $urandom_range(0, 4);
            else if (m_busy && !mem_resp_en) begin
                if (mem_delay == 0) begin mem_resp_en = 1'b1; mem_resp_data = $urandom; end
                else mem_delay--;
            end
            if (!st_req_en && !new_pulse[2] && $urandom_range(0, 2) == 0) begin
                st_req_en = 1'b1; st_req_addr = $urandom; st_req_data = $urandom;
                st_req_width = 2'($urandom_range(0, 2));
            end
            if (!ld_req_en && !new_pulse[1] && $urandom_range(0, 2) == 0) begin
                ld_req_en = 1'b1; ld_req_addr = $urandom; ld_req_width = 2'($urandom_range(0, 2));
            end
            if (!ic_req_en && !new_pulse[0] && $urandom_range(0, 2) == 0) begin
                ic_req_en = 1'b1; ic_req_addr = $urandom;
            end
            flush_signal = ($urandom_range(0, 9) == 0);
            if (flush_signal) begin ld_req_en = 1'b0; ic_req_en = 1'b0; end
            rdy_in = ($urandom_range(0, 7) != 0);
            latchInputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
